// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg -- shared definitions for the sram_ctrl block.
//
// Holds the controller state encoding and the enum built on it. It also holds
// PAR_W, the number of extra SRAM bits per word. PAR_W is 1 when the optional
// parity feature is built (macro SRAM_CTRL_PARITY_EN defined) and 0 otherwise.
package sram_ctrl_pkg;

    localparam logic [2:0] ST_INIT_C    = 3'd0;
    localparam logic [2:0] ST_IDLE_C    = 3'd1;
    localparam logic [2:0] ST_ISSUE_C   = 3'd2;
    localparam logic [2:0] ST_CAPTURE_C = 3'd3;
    localparam logic [2:0] ST_RSP_C     = 3'd4;

    typedef enum logic [2:0] {
        S_INIT    = ST_INIT_C,
        S_IDLE    = ST_IDLE_C,
        S_ISSUE   = ST_ISSUE_C,
        S_CAPTURE = ST_CAPTURE_C,
        S_RSP     = ST_RSP_C
    } state_t;

`ifdef SRAM_CTRL_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl -- single-port synchronous SRAM controller with a clearing sweep.
//
// After reset the controller writes zero to every word 0..DEPTH-1, one word per
// cycle. It then raises init_done and accepts one request at a time.
// A write occupies the SRAM for one ISSUE cycle.
// A read goes through ISSUE, then CAPTURE, then RSP. The read data is held in RSP
// until the consumer takes it. Addresses at or above DEPTH do not touch the
// stored data: such writes are dropped and such reads return zero.
//
// Optional feature: macro SRAM_CTRL_PARITY_EN. With it defined, the SRAM word
// gains an even-parity MSB. The parity is checked on reads and reported on
// rsp_perr.
//
// Ports:
//   i_clk      clock, rising edge
//   rst        synchronous active-low reset
//   req_valid / req_ready / req_write / req_addr / req_wdata   request channel
//   rsp_valid / rsp_ready / rsp_rdata (/ rsp_perr)             read response
//   init_done  clearing sweep finished
//   m_addr / m_write / m_wdata / m_rdata                       SRAM side; m_rdata
//              comes from the SRAM's output register
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                        i_clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    input  logic [DATA_WIDTH-1:0]       req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
`ifdef SRAM_CTRL_PARITY_EN
    output logic                        rsp_perr,
`endif
    output logic                        init_done,
    output logic [ADDR_WIDTH-1:0]       m_addr,
    output logic                        m_write,
    output logic [DATA_WIDTH+PAR_W-1:0] m_wdata,
    input  logic [DATA_WIDTH+PAR_W-1:0] m_rdata
);

    localparam int MW = DATA_WIDTH + PAR_W;
    // The sweep counter is one bit wider than the address so it can hold DEPTH
    // itself. That value marks the end of the sweep.
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_sweep;
    logic                  r_cap_wait;
    logic                  r_write;
    logic                  r_oor;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_init_done;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic                  r_m_write;
    logic [MW-1:0]         r_m_wdata;

    logic                  w_hs;
    logic                  w_in_range;
    logic [MW-1:0]         w_wdata;
    logic                  w_rd_perr;

`ifdef SRAM_CTRL_PARITY_EN
    logic                  r_rsp_perr;

    // The parity bit makes the total count of ones in the stored word even.
    function automatic logic even_par(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    assign w_wdata   = {even_par(req_wdata), req_wdata};
    // Any odd count of ones across data and parity means the word was corrupted.
    assign w_rd_perr = ^m_rdata;
    assign rsp_perr  = r_rsp_perr;
`else
    assign w_wdata   = req_wdata;
    assign w_rd_perr = 1'b0;
`endif

    assign w_hs       = req_valid & r_req_ready;
    assign w_in_range = ({1'b0, req_addr} < DEPTH_C);

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign init_done  = r_init_done;
    assign m_addr     = r_m_addr;
    assign m_write    = r_m_write;
    assign m_wdata    = r_m_wdata;

    // Controller FSM; every output is a register updated here.
    always_ff @(posedge i_clk) begin
        if (!rst) begin
            r_state     <= S_INIT;
            r_sweep     <= {(ADDR_WIDTH+1){1'b0}};
            r_cap_wait  <= 1'b0;
            r_write     <= 1'b0;
            r_oor       <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {DATA_WIDTH{1'b0}};
            r_init_done <= 1'b0;
            r_m_addr    <= {ADDR_WIDTH{1'b0}};
            r_m_write   <= 1'b0;
            r_m_wdata   <= {MW{1'b0}};
`ifdef SRAM_CTRL_PARITY_EN
            r_rsp_perr  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_sweep < DEPTH_C) begin
                        r_m_addr  <= r_sweep[ADDR_WIDTH-1:0];
                        r_m_write <= 1'b1;
                        r_m_wdata <= {MW{1'b0}};
                        r_sweep   <= r_sweep + ONE_C;
                    end else begin
                        r_m_write   <= 1'b0;
                        r_init_done <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_hs) begin
                        r_m_addr    <= req_addr;
                        r_m_wdata   <= w_wdata;
                        // An out-of-range write never reaches the SRAM.
                        r_m_write   <= req_write & w_in_range;
                        r_write     <= req_write;
                        r_oor       <= ~w_in_range;
                        r_req_ready <= 1'b0;
                        r_state     <= S_ISSUE;
                    end else begin
                        r_m_write   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_m_write <= 1'b0;
                    if (r_write) begin
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cap_wait  <= 1'b1;
                        r_state     <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    // The SRAM output register shows the addressed word one
                    // cycle into CAPTURE, so the data is sampled on the second
                    // CAPTURE edge. m_addr is held throughout CAPTURE.
                    if (r_cap_wait) begin
                        r_cap_wait <= 1'b0;
                    end else begin
                        r_rsp_rdata <= r_oor ? {DATA_WIDTH{1'b0}} : m_rdata[DATA_WIDTH-1:0];
`ifdef SRAM_CTRL_PARITY_EN
                        r_rsp_perr  <= r_oor ? 1'b0 : w_rd_perr;
`endif
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_m_write   <= 1'b0;
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_sweep     <= {(ADDR_WIDTH+1){1'b0}};
                    r_init_done <= 1'b0;
                    r_state     <= S_INIT;
                end
            endcase
        end
    end

    // Without the parity feature the check result has no consumer.
    logic w_unused;
    assign w_unused = w_rd_perr;

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, user data width.
REQ-003 SHALL have parameter DEPTH, default 16, number of words; legal range 2..2^ADDR_WIDTH.
REQ-004 SHALL have port i_clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-008 SHALL have port req_write  input  1  1=write, 0=read.
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH  request address.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port rsp_valid  output  1  read data available.
REQ-012 SHALL have port rsp_ready  input  1  consumer takes rsp_rdata.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH  read data.
REQ-014 SHALL have port init_done  output  1  clear sweep complete.
REQ-015 SHALL have port m_addr  output  ADDR_WIDTH  SRAM address.
REQ-016 SHALL have port m_write  output  1  SRAM write enable.
REQ-017 SHALL have port m_wdata  output  MW  SRAM write data; MW=DATA_WIDTH, or DATA_WIDTH+1 with parity.
REQ-018 SHALL have port m_rdata  input  MW  SRAM read data, registered, valid one cycle after a non-write address cycle.

Function
REQ-019 States SHALL be INIT, IDLE, ISSUE, CAPTURE, RSP.
REQ-020 INIT SHALL drive m_write=1, m_wdata=0, m_addr=sweep counter 0..DEPTH-1, one word per cycle, then go IDLE and set init_done=1.
REQ-021 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready on an edge.
REQ-022 On handshake SHALL register addr/write/wdata and enter ISSUE; m_* outputs are registered and valid throughout ISSUE.
REQ-023 Write: ISSUE drives m_write=1 for exactly one cycle, then IDLE; back-to-back accepted writes are spaced 2 cycles apart.
REQ-024 Read: ISSUE drives m_write=0; CAPTURE latches m_rdata into rsp_rdata; RSP holds rsp_valid=1 and stable rsp_rdata until rsp_ready, then IDLE.
REQ-025 Read latency SHALL be 3 cycles from handshake edge to rsp_valid rising.
REQ-026 Address >= DEPTH: write SHALL be dropped (m_write=0 in ISSUE); read SHALL return rsp_rdata=0.
REQ-027 m_write SHALL be 0 in IDLE, CAPTURE and RSP.
REQ-028 rsp_ready while rsp_valid=0 SHALL be ignored.

Reset
REQ-029 rst=0 at any edge, in any state, SHALL force INIT, sweep counter=0, init_done=0, req_ready=0, rsp_valid=0, rsp_rdata=0, m_addr=0; a pending read response is discarded.
REQ-030 Sweep SHALL restart from address 0 when rst is released; no request is accepted until sweep ends.

Configuration
REQ-031 Macro SRAM_CTRL_PARITY_EN defined: MW=DATA_WIDTH+1, even parity bit stored in MSB on writes (0 during sweep), checked in CAPTURE; extra output rsp_perr  output  1, valid with rsp_valid, reset 0.
REQ-032 Macro undefined: MW=DATA_WIDTH, no rsp_perr port, no parity logic.

Structure
REQ-033 Shared package sram_ctrl_pkg SHALL hold the state enum and state encoding constants.
REQ-034 No sub-module; the SRAM is instantiated by the parent, not inside this block.

Verification
REQ-035 Release rst -> m_write=1 at addresses 0..15 with m_wdata=0 for 16 cycles, then init_done=1, req_ready=1.
REQ-036 Write addr 3 data 0xDEADBEEF, read addr 3 -> rsp_valid 3 cycles after read handshake, rsp_rdata=0xDEADBEEF.
REQ-037 Read addr 5 with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata held stable, req_ready=0 until rsp_ready=1.
REQ-038 DEPTH=12, write addr 14 -> no m_write pulse; read addr 14 -> rsp_rdata=0.
REQ-039 rst=0 during RSP -> rsp_valid=0 next cycle, full sweep reruns, prior data at addr 3 reads back 0.
REQ-040 With SRAM_CTRL_PARITY_EN, model flips m_rdata bit 0 on read -> rsp_perr=1; clean read -> rsp_perr=0.
